// File: rtl/game_ctrl_pkg.sv
// Shared definitions for the switch-matching game controller: state encoding,
// default timing/score constants and the score saturation helper.
package game_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_PLAY  = 3'd2,
    ST_BREAK = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  localparam int ROUND_TIME_DEF = 15;
  localparam int BREAK_TIME_DEF = 5;
  localparam int SCORE_MAX_DEF  = 9999;
  localparam int BONUS_PERIOD   = 5;

  localparam int SW_W    = 10;
  localparam int CNT_W   = 6;
  localparam int SCORE_W = 14;
  localparam int ROUND_W = 7;
  // Internal score arithmetic width; holds (SCORE_MAX + 2) * 2 without wrap.
  localparam int CALC_W  = 16;

  function automatic logic [CALC_W-1:0] sat_score(input logic [CALC_W-1:0] value,
                                                  input logic [CALC_W-1:0] ceiling);
    return (value > ceiling) ? ceiling : value;
  endfunction

endpackage

// File: rtl/game_ctrl_score_unit.sv
// Score and round counter: +2 per pass, doubled every BONUS_PERIOD-th round,
// saturating at SCORE_MAX; round_num saturates at its all-ones value.
module score_unit
  import game_ctrl_pkg::*;
#(
  parameter int SCORE_MAX = SCORE_MAX_DEF
) (
  input  logic               clk,
  input  logic               reset_btn,
  input  logic               pass_stb,
  input  logic               clear_stb,
  output logic [SCORE_W-1:0] score,
  output logic [ROUND_W-1:0] round_num
);

  logic [ROUND_W-1:0] round_next;
  logic [CALC_W-1:0]  s1;
  logic [CALC_W-1:0]  s_sat;
  logic [SCORE_W-1:0] score_next;

  // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
  always_comb begin
    round_next = (round_num == {ROUND_W{1'b1}}) ? round_num : round_num + 1'b1;
    s1         = CALC_W'(score) + CALC_W'(2);
    if ((round_next % ROUND_W'(BONUS_PERIOD)) == '0) begin
      s1 = s1 << 1;
    end
    s_sat      = sat_score(s1, CALC_W'(SCORE_MAX));
    score_next = s_sat[SCORE_W-1:0];
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset_btn || clear_stb) begin
      score     <= '0;
      round_num <= '0;
    end else if (pass_stb) begin
      score     <= score_next;
      round_num <= round_next;
    end
  end

endmodule

// File: rtl/game_ctrl.sv
// Game controller: requests a prompt, times the player's switch move, and
// steps through break/over phases; score bookkeeping lives in score_unit.
module game_ctrl
  import game_ctrl_pkg::*;
#(
  parameter int ROUND_TIME = ROUND_TIME_DEF,
  parameter int BREAK_TIME = BREAK_TIME_DEF,
  parameter int SCORE_MAX  = SCORE_MAX_DEF
) (
  input  logic               clk,
  input  logic               reset_btn,
  input  logic               tick_1hz,
  input  logic               start_btn,
  input  logic [SW_W-1:0]    sw,
  input  logic               prompt_valid,
  input  logic [SW_W-1:0]    prompt_expected,
  input  logic [SW_W-1:0]    prompt_mask,
  output logic               prompt_req,
  output logic [SW_W-1:0]    led_out,
  output logic [CNT_W-1:0]   count_sec,
  output logic [SCORE_W-1:0] score,
  output logic [ROUND_W-1:0] round_num,
  output logic               game_over
);

  state_t          state;
  logic [SW_W-1:0] exp_q;
  logic [SW_W-1:0] mask_q;

  logic pass_hit;
  logic wrong_hit;
  logic last_tick;
  logic pass_stb;
  logic clear_stb;

  always_comb begin
    pass_hit  = (sw == exp_q);
    wrong_hit = |((sw ^ exp_q) & ~mask_q);
    last_tick = tick_1hz && (count_sec <= CNT_W'(1));
    pass_stb  = (state == ST_PLAY) && pass_hit;
    clear_stb = (state == ST_OVER) && start_btn;
  end

  always_ff @(posedge clk) begin
    if (reset_btn) begin
      // NOTE: the latched prompt is reset too, so a stale target never survives a reset.
      state      <= ST_IDLE;
      prompt_req <= 1'b0;
      led_out    <= '0;
      count_sec  <= '0;
      game_over  <= 1'b0;
      exp_q      <= '0;
      mask_q     <= '0;
    end else begin
      prompt_req <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_btn) begin
            state      <= ST_REQ;
            prompt_req <= 1'b1;
          end
        end

        ST_REQ: begin
          if (prompt_valid) begin
            exp_q     <= prompt_expected;
            mask_q    <= prompt_mask;
            led_out   <= prompt_mask;
            count_sec <= CNT_W'(ROUND_TIME);
            state     <= ST_PLAY;
          end
        end

        // Priority: pass, then wrong switch, then timeout on the final tick.
        ST_PLAY: begin
          if (pass_hit) begin
            count_sec <= CNT_W'(BREAK_TIME);
            led_out   <= '0;
            state     <= ST_BREAK;
          end else if (wrong_hit) begin
            led_out   <= '0;
            game_over <= 1'b1;
            state     <= ST_OVER;
          end else if (tick_1hz) begin
            if (last_tick) begin
              count_sec <= '0;
              led_out   <= '0;
              game_over <= 1'b1;
              state     <= ST_OVER;
            end else begin
              count_sec <= count_sec - 1'b1;
            end
          end
        end

        ST_BREAK: begin
          if (count_sec == '0 || last_tick) begin
            count_sec  <= '0;
            prompt_req <= 1'b1;
            state      <= ST_REQ;
          end else if (tick_1hz) begin
            count_sec <= count_sec - 1'b1;
          end
        end

        ST_OVER: begin
          if (start_btn) begin
            game_over  <= 1'b0;
            prompt_req <= 1'b1;
            state      <= ST_REQ;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  score_unit #(
    .SCORE_MAX(SCORE_MAX)
  ) u_score (
    .clk      (clk),
    .reset_btn(reset_btn),
    .pass_stb (pass_stb),
    .clear_stb(clear_stb),
    .score    (score),
    .round_num(round_num)
  );

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl: round flow, bonus scoring, fail paths,
// timeout edge, saturation and reset dominance.
module tb_game_ctrl;

  logic        clk = 1'b0;
  logic        reset_btn = 1'b0;
  logic        tick_1hz = 1'b0;
  logic        start_btn = 1'b0;
  logic [9:0]  sw = '0;
  logic        prompt_valid = 1'b0;
  logic [9:0]  prompt_expected = '0;
  logic [9:0]  prompt_mask = '0;
  logic        prompt_req;
  logic [9:0]  led_out;
  logic [5:0]  count_sec;
  logic [13:0] score;
  logic [6:0]  round_num;
  logic        game_over;

  int errors = 0;
  int checks = 0;
  int ms = 0;
  int mr = 0;
  int exp_sc[4] = '{4, 6, 8, 20};

  game_ctrl dut (
    .clk            (clk),
    .reset_btn      (reset_btn),
    .tick_1hz       (tick_1hz),
    .start_btn      (start_btn),
    .sw             (sw),
    .prompt_valid   (prompt_valid),
    .prompt_expected(prompt_expected),
    .prompt_mask    (prompt_mask),
    .prompt_req     (prompt_req),
    .led_out        (led_out),
    .count_sec      (count_sec),
    .score          (score),
    .round_num      (round_num),
    .game_over      (game_over)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input int got, input int expv);
    checks++;
    if (got != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_btn = 1'b1;
    step();
    reset_btn = 1'b0;
  endtask

  task automatic pulse_start();
    start_btn = 1'b1;
    step();
    start_btn = 1'b0;
  endtask

  task automatic pulse_tick();
    tick_1hz = 1'b1;
    step();
    tick_1hz = 1'b0;
  endtask

  task automatic give_prompt(input logic [9:0] e, input logic [9:0] m);
    prompt_expected = e;
    prompt_mask     = m;
    prompt_valid    = 1'b1;
    step();
    prompt_valid    = 1'b0;
  endtask

  // From REQ: prompt toggling one bit, then the player matches it.
  task automatic pass_round(input int k);
    logic [9:0] m;
    logic [9:0] e;
    m = 10'(1) << (k % 10);
    e = sw ^ m;
    give_prompt(e, m);
    sw = e;
    step();
  endtask

  task automatic finish_break();
    int n;
    n = 0;
    while (!prompt_req && n < 8) begin
      pulse_tick();
      n++;
    end
    check("break_end_req", int'(prompt_req), 1);
    check("break_end_cnt", int'(count_sec), 0);
    step();
  endtask

  function automatic int model_next_score(input int s, input int r_new);
    int s1;
    s1 = s + 2;
    if (r_new % 5 == 0) s1 = s1 * 2;
    if (s1 > 9999) s1 = 9999;
    return s1;
  endfunction

  initial begin
    // Reset state
    step();
    do_reset();
    check("rst_prompt_req", int'(prompt_req), 0);
    check("rst_led", int'(led_out), 0);
    check("rst_cnt", int'(count_sec), 0);
    check("rst_score", int'(score), 0);
    check("rst_round", int'(round_num), 0);
    check("rst_over", int'(game_over), 0);

    // Start, single prompt_req pulse, REQ waits
    pulse_start();
    check("start_req_hi", int'(prompt_req), 1);
    step();
    check("start_req_lo", int'(prompt_req), 0);
    step();
    check("req_wait_lo", int'(prompt_req), 0);

    // First round: expected=001, mask=001, sw=0 then matched
    give_prompt(10'h001, 10'h001);
    check("play_led", int'(led_out), 1);
    check("play_cnt", int'(count_sec), 15);
    check("play_over", int'(game_over), 0);
    step();
    check("play_hold_cnt", int'(count_sec), 15);
    sw = 10'h001;
    step();
    check("r1_cnt", int'(count_sec), 5);
    check("r1_score", int'(score), 2);
    check("r1_round", int'(round_num), 1);
    check("r1_led", int'(led_out), 0);
    // Switch changes in BREAK are ignored; start ignored too
    sw = 10'h3F0;
    start_btn = 1'b1;
    step();
    start_btn = 1'b0;
    check("brk_sw_cnt", int'(count_sec), 5);
    check("brk_sw_over", int'(game_over), 0);
    check("brk_start_req", int'(prompt_req), 0);
    pulse_tick();
    check("brk_tick1", int'(count_sec), 4);
    finish_break();

    // Rounds 2..5: 4, 6, 8, 20
    for (int i = 0; i < 4; i++) begin
      pass_round(i + 1);
      check($sformatf("seq_score_%0d", i + 2), int'(score), exp_sc[i]);
      check($sformatf("seq_round_%0d", i + 2), int'(round_num), i + 2);
      finish_break();
    end

    // Wrong switch: mask=004, bit 7 toggled
    give_prompt(sw ^ 10'h004, 10'h004);
    sw = sw ^ 10'h080;
    step();
    check("wrong_over", int'(game_over), 1);
    check("wrong_score", int'(score), 20);
    check("wrong_led", int'(led_out), 0);
    check("wrong_cnt", int'(count_sec), 15);
    pulse_tick();
    check("over_tick_ign", int'(count_sec), 15);

    // Start in OVER: clears score/round, straight to REQ
    pulse_start();
    check("restart_req", int'(prompt_req), 1);
    check("restart_score", int'(score), 0);
    check("restart_round", int'(round_num), 0);
    check("restart_over", int'(game_over), 0);
    step();
    check("restart_req_lo", int'(prompt_req), 0);

    // Timeout: 15 ticks without touching the switches
    give_prompt(sw ^ 10'h010, 10'h010);
    for (int i = 1; i <= 15; i++) begin
      pulse_tick();
      check($sformatf("to_cnt_%0d", i), int'(count_sec), 15 - i);
      check($sformatf("to_over_%0d", i), int'(game_over), (i == 15) ? 1 : 0);
    end
    check("to_score", int'(score), 0);

    // Pass on the final-tick clk counts as a pass
    pulse_start();
    step();
    give_prompt(sw ^ 10'h020, 10'h020);
    for (int i = 0; i < 14; i++) pulse_tick();
    check("edge_cnt1", int'(count_sec), 1);
    sw = prompt_expected;
    pulse_tick();
    check("edge_over", int'(game_over), 0);
    check("edge_cnt", int'(count_sec), 5);
    check("edge_score", int'(score), 2);
    check("edge_round", int'(round_num), 1);

    // Reset mid-BREAK at count 3 dominates simultaneous tick/start
    pulse_tick();
    pulse_tick();
    check("mid_brk_cnt", int'(count_sec), 3);
    reset_btn = 1'b1;
    tick_1hz  = 1'b1;
    start_btn = 1'b1;
    step();
    reset_btn = 1'b0;
    tick_1hz  = 1'b0;
    start_btn = 1'b0;
    check("brk_rst_cnt", int'(count_sec), 0);
    check("brk_rst_score", int'(score), 0);
    check("brk_rst_round", int'(round_num), 0);
    check("brk_rst_req", int'(prompt_req), 0);
    check("brk_rst_over", int'(game_over), 0);
    check("brk_rst_led", int'(led_out), 0);
    pulse_start();
    check("post_rst_start", int'(prompt_req), 1);
    step();

    // Saturation: 50 passes from zero, score must reach and hold 9999
    ms = 0;
    mr = 0;
    for (int k = 1; k <= 50; k++) begin
      pass_round(k);
      mr = (mr < 127) ? mr + 1 : 127;
      ms = model_next_score(ms, mr);
      check($sformatf("sat_score_%0d", k), int'(score), ms);
      if (score > 14'd9999) check($sformatf("sat_ceiling_%0d", k), int'(score), 9999);
      finish_break();
    end
    check("sat_final", int'(score), 9999);
    check("sat_round", int'(round_num), 50);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 The block SHALL have parameter ROUND_TIME, default 15, meaning the seconds allowed per round.
REQ-002 The block SHALL have parameter BREAK_TIME, default 5, meaning the seconds of pause between rounds.
REQ-003 The block SHALL have parameter SCORE_MAX, default 9999, meaning the score saturation ceiling.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, 50 MHz CLOCK_50 domain.
REQ-005 The block SHALL have port reset_btn, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port tick_1hz, input, 1 bit: one-clk strobe once per second.
REQ-007 The block SHALL have port start_btn, input, 1 bit: one-clk start pulse, synchronised upstream.
REQ-008 The block SHALL have port sw, input, 10 bits: live switch levels.
REQ-009 The block SHALL have port prompt_valid, input, 1 bit: the prompt generator's new-prompt strobe.
REQ-010 The block SHALL have port prompt_expected, input, 10 bits: the switch arrangement the player must reach.
REQ-011 The block SHALL have port prompt_mask, input, 10 bits: one-hot marking the switch to toggle.
REQ-012 The block SHALL have port prompt_req, output, 1 bit: one-clk request for a new prompt.
REQ-013 The block SHALL have port led_out, output, 10 bits: the latched prompt_mask shown on LEDR.
REQ-014 The block SHALL have port count_sec, output, 6 bits: remaining seconds, for the timer display.
REQ-015 The block SHALL have port score, output, 14 bits: binary score.
REQ-016 The block SHALL have port round_num, output, 7 bits: rounds passed, saturating at 127.
REQ-017 The block SHALL have port game_over, output, 1 bit: high while in the OVER state.

Function
REQ-018 The FSM SHALL have the states IDLE, REQ, PLAY, BREAK and OVER.
REQ-019 In IDLE, start_btn SHALL move the FSM to REQ.
REQ-020 On entry to REQ, prompt_req SHALL be high for exactly one clk.
REQ-021 In REQ, the FSM SHALL wait indefinitely for prompt_valid.
REQ-022 On prompt_valid in REQ, the block SHALL latch prompt_expected and prompt_mask, set count_sec=ROUND_TIME and enter PLAY on the next clk.
REQ-023 In PLAY, a pass SHALL be recognised when sw==expected.
REQ-024 In PLAY, a fail SHALL be recognised when ((sw^expected)&~mask)!=0, i.e. a wrong switch was moved.
REQ-025 In PLAY, tick_1hz SHALL decrement count_sec.
REQ-026 A tick that takes count_sec from 1 to 0 without a pass in that cycle SHALL be a fail.
REQ-027 Event priority in PLAY SHALL be pass > wrong-switch fail > timeout fail.
REQ-028 A pass and the final tick in the same clk SHALL count as a pass.
REQ-029 On a pass, the block SHALL set round_num+=1 and update score, then set count_sec=BREAK_TIME, enter BREAK and clear led_out.
REQ-030 On a fail, the block SHALL enter OVER, freeze count_sec, freeze score and clear led_out.
REQ-031 In BREAK, tick_1hz SHALL decrement count_sec.
REQ-032 In BREAK, reaching 0 SHALL move the FSM to REQ; sw changes SHALL be ignored.
REQ-033 The score update SHALL be s1 = score+2, followed by s1 = 2*s1 if the new round_num is a multiple of 5, all computed at ≥15 bits and saturated at SCORE_MAX.
REQ-034 In OVER, start_btn SHALL clear score and round_num and enter REQ directly.
REQ-035 start_btn SHALL be ignored in REQ, PLAY and BREAK.
REQ-036 tick_1hz SHALL be ignored in IDLE, REQ and OVER.
REQ-037 count_sec SHALL never underflow below 0.
REQ-038 Outputs SHALL be registered, with one clk latency from the causing input.

Reset
REQ-039 A reset_btn that is high at a clk edge SHALL force IDLE, prompt_req=0, led_out=0, count_sec=0, score=0, round_num=0, game_over=0 and clear the latched prompt.
REQ-040 Reset SHALL dominate every other input on the same clk, including mid-PLAY and mid-BREAK.
REQ-041 After reset is released, the first accepted start_btn SHALL be on the following clk.

Structure
REQ-042 A shared package SHALL hold the state encoding (3-bit enum), the ROUND_TIME/BREAK_TIME/SCORE_MAX defaults and the bonus period constant 5.
REQ-043 One sub-module, score_unit, SHALL hold the combinational-plus-register score and round_num update with saturation, enabled by a pass strobe and a clear strobe.
REQ-044 The FSM, the countdown and the prompt latch SHALL stay in game_ctrl.

Verification
REQ-045 The bench SHALL check: reset, start, prompt_valid with expected=10'h001, mask=10'h001 while sw=0, then sw=10'h001 before any tick -> one prompt_req pulse, then PLAY, then BREAK with count_sec=5, score=2, round_num=1.
REQ-046 The bench SHALL check: five consecutive passes -> score sequence 2, 4, 6, 8, 20, and round_num=5.
REQ-047 The bench SHALL check: in PLAY with mask=10'h004, sw bit 7 toggled -> OVER, game_over=1 next clk, score unchanged, led_out=0.
REQ-048 The bench SHALL check: 15 ticks with no switch change -> count_sec goes 15 down to 0 then OVER; the variant with sw matching on the 15th tick clk -> BREAK, not OVER.
REQ-049 The bench SHALL check: score preloaded near the ceiling by repeated passes -> score never exceeds 9999 and holds at 9999.
REQ-050 The bench SHALL check: reset_btn asserted mid-BREAK with count_sec=3 -> IDLE with all outputs zero next clk; start_btn in OVER -> score=0 and prompt_req pulses.
